// File: rtl/ps2_key_state_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_state_tracker_pkg
//   Shared constants for the PS/2 key state tracker:
//     - PS/2 prefix bytes (break 8'hF0, extended 8'hE0)
//     - decoder FSM state encodings (kept as plain 2-bit constants so legacy
//       code comparing against the old encodings still lines up)
//     - scancode -> key index lookup for the 29 tracked keys, in the same
//       index order as the keyboard input table used by the top level
// ----------------------------------------------------------------------------
package ps2_key_state_tracker_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int unsigned NUMBER_OF_KEYBOARD_INPUTS = 29;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BRK     = 2'd1;
    localparam logic [1:0] S_EXT     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_lookup_t;

    function automatic key_lookup_t scancode_lookup(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = '0;
        case (code)
            8'h0E: r.idx = 5'd0;
            8'h16: r.idx = 5'd1;
            8'h1E: r.idx = 5'd2;
            8'h26: r.idx = 5'd3;
            8'h25: r.idx = 5'd4;
            8'h2E: r.idx = 5'd5;
            8'h36: r.idx = 5'd6;
            8'h3D: r.idx = 5'd7;
            8'h3E: r.idx = 5'd8;
            8'h46: r.idx = 5'd9;
            8'h45: r.idx = 5'd10;
            8'h4E: r.idx = 5'd11;
            8'h55: r.idx = 5'd12;
            8'h66: r.idx = 5'd13;
            8'h0D: r.idx = 5'd14;
            8'h15: r.idx = 5'd15;
            8'h1D: r.idx = 5'd16;
            8'h24: r.idx = 5'd17;
            8'h2D: r.idx = 5'd18;
            8'h2C: r.idx = 5'd19;
            8'h35: r.idx = 5'd20;
            8'h3C: r.idx = 5'd21;
            8'h43: r.idx = 5'd22;
            8'h44: r.idx = 5'd23;
            8'h4D: r.idx = 5'd24;
            8'h54: r.idx = 5'd25;
            8'h5B: r.idx = 5'd26;
            8'h5D: r.idx = 5'd27;
            8'h29: r.idx = 5'd28;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_state_tracker_key_event_fifo.sv
// ----------------------------------------------------------------------------
// key_event_fifo
//   First-word-fall-through FIFO for key press/release events.
//   Ports:
//     clk       in   clock, posedge
//     rst       in   synchronous active-high reset
//     push      in   write request
//     push_data in   WIDTH  entry to write
//     pop       in   remove head (ignored when empty)
//     head      out  WIDTH  head entry, forced to zero while empty
//     valid     out  FIFO non-empty
//     overflow  out  sticky: a push was dropped while full (reset only)
//   A push while full is accepted when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module key_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        valid   = !empty;
        head    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_state_tracker
//   PS/2 make/break decoder keeping a per-key pressed vector and queueing
//   press/release events for the record/playback path.
//   Ports:
//     CLOCK_50      in   system clock, posedge
//     resetn        in   synchronous ACTIVE-HIGH reset (name kept for
//                        compatibility; top level drives ~KEY[0])
//     ps2_byte      in   8  received byte
//     ps2_byte_vld  in   one-cycle strobe, ps2_byte valid
//     clear_all     in   clears key_state and decoder; FIFO kept
//     key_state     out  NUM_KEYS  bit i set while key i held
//     evt_valid     out  event FIFO non-empty
//     evt_key       out  KEY_IDX_W key index of head event
//     evt_release   out  head event: 0 press, 1 release
//     evt_ready     in   pop head when evt_valid & evt_ready
//     evt_overflow  out  sticky: event dropped on full FIFO
//   Build option: KEY_TYPEMATIC_FILTER_EN suppresses events for makes of
//   already-held keys and breaks of unheld keys; key_state is unaffected.
// ----------------------------------------------------------------------------
module ps2_key_state_tracker
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int NUM_KEYS   = 29,
    parameter int KEY_IDX_W  = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [7:0]           ps2_byte,
    input  logic                 ps2_byte_vld,
    input  logic                 clear_all,
    output logic [NUM_KEYS-1:0]  key_state,
    output logic                 evt_valid,
    output logic [KEY_IDX_W-1:0] evt_key,
    output logic                 evt_release,
    input  logic                 evt_ready,
    output logic                 evt_overflow
);

    logic [1:0]          state;
    logic [1:0]          state_next;
    key_lookup_t         lk;
    logic                mapped;
    logic                accept;
    logic                do_press;
    logic                do_release;
    logic                key_held;
    logic                evt_push;
    logic [NUM_KEYS-1:0] key_mask;
    logic [KEY_IDX_W:0]  evt_data;
    logic [KEY_IDX_W:0]  evt_head;

    always_comb begin
        lk       = scancode_lookup(ps2_byte);
        mapped   = lk.hit && (32'(lk.idx) < NUM_KEYS);
        key_mask = NUM_KEYS'(1) << lk.idx;
        key_held = |(key_state & key_mask);
        // clear_all outranks a byte strobed in the same cycle
        accept   = ps2_byte_vld && !clear_all;
    end

    always_comb begin
        state_next = state;
        do_press   = 1'b0;
        do_release = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (ps2_byte == PS2_BREAK)    state_next = S_BRK;
                    else if (ps2_byte == PS2_EXT) state_next = S_EXT;
                    else if (mapped)              do_press   = 1'b1;
                end
                S_BRK: begin
                    // A repeated prefix restarts the sequence rather than
                    // being taken as the key being released.
                    if (ps2_byte == PS2_BREAK) begin
                        state_next = S_BRK;
                    end else if (ps2_byte == PS2_EXT) begin
                        state_next = S_EXT;
                    end else begin
                        do_release = mapped;
                        state_next = S_IDLE;
                    end
                end
                S_EXT: begin
                    state_next = (ps2_byte == PS2_BREAK) ? S_EXT_BRK : S_IDLE;
                end
                S_EXT_BRK: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
`ifdef KEY_TYPEMATIC_FILTER_EN
        evt_push = (do_press && !key_held) || (do_release && key_held);
`else
        evt_push = do_press || do_release;
`endif
        evt_data = {KEY_IDX_W'(lk.idx), do_release};
    end

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            state     <= S_IDLE;
            key_state <= '0;
        end else if (clear_all) begin
            state     <= S_IDLE;
            key_state <= '0;
        end else begin
            state <= state_next;
            if (do_press)        key_state <= key_state | key_mask;
            else if (do_release) key_state <= key_state & ~key_mask;
        end
    end

    key_event_fifo #(
        .WIDTH (KEY_IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (CLOCK_50),
        .rst       (resetn),
        .push      (evt_push),
        .push_data (evt_data),
        .pop       (evt_ready),
        .head      (evt_head),
        .valid     (evt_valid),
        .overflow  (evt_overflow)
    );

    assign evt_key     = evt_head[KEY_IDX_W:1];
    assign evt_release = evt_head[0];

endmodule
